// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - instruction input handshake and instruction-memory write bus
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [5:0]        opcode;
    logic [4:0]        rdst2;
    logic [4:0]        rdst1;
    logic [4:0]        rsrc2;
    logic [4:0]        rsrc1;
    logic [15:0]       imm;
    logic [7:0]        src_addr;
    logic [7:0]        dst_addr;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: instruction source and memory sink; slave: the encoder
    modport master (
        output in_valid, in_last, opcode, rdst2, rdst1, rsrc2, rsrc1, imm,
               src_addr, dst_addr, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, opcode, rdst2, rdst1, rsrc2, rsrc1, imm,
               src_addr, dst_addr, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into 32-bit words and loads them into imem
// Optional running XOR checksum of written words when ENC_CHECKSUM_EN is defined.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic [ADDR_W:0]   words,
    output logic [31:0]       checksum
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              pend_q;
    logic              pend_last_q;
    logic              last_seen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   words_q;
    logic              err_ill_q;
    logic              err_ovf_q;

    logic              retire;
    logic              addr_max;
    logic              legal;
    logic              in_ready_c;
    logic              accept;
    logic              ovf_hit;
    logic              start_run;
    logic [31:0]       enc;

    assign start_run = (state_q == S_IDLE) && start;
    assign retire    = pend_q && bus.imem_ready;
    assign addr_max  = &addr_q;
    assign legal     = (bus.opcode <= 6'h10);
    // A write retiring at the top address cannot be followed by another word
    assign in_ready_c = (state_q == S_RUN) && !last_seen_q &&
                        (!pend_q || (bus.imem_ready && !addr_max));
    assign accept    = bus.in_valid && in_ready_c;
    assign ovf_hit   = retire && addr_max && !pend_last_q;

    always_comb begin
        enc = 32'h0;
        if (bus.opcode == 6'h00)
            enc = {bus.opcode, bus.rdst2, 5'b0, bus.imm};
        else if (bus.opcode == 6'h01)
            enc = {bus.opcode, bus.rdst2, 16'b0, bus.rsrc2};
        else if (bus.opcode == 6'h02)
            enc = {bus.opcode, bus.rdst2, 13'b0, bus.src_addr};
        else if (bus.opcode == 6'h03)
            enc = {bus.opcode, bus.dst_addr, 13'b0, bus.rsrc2};
        else if (legal)
            enc = {bus.opcode, bus.rdst2, bus.rdst1, 6'b0, bus.rsrc2, bus.rsrc1};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if ((retire && pend_last_q) || ovf_hit ||
                    (accept && !legal && bus.in_last))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            last_seen_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            words_q     <= '0;
            err_ill_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                addr_q      <= base_addr;
                words_q     <= '0;
                err_ill_q   <= 1'b0;
                err_ovf_q   <= 1'b0;
                last_seen_q <= 1'b0;
                pend_q      <= 1'b0;
                pend_last_q <= 1'b0;
            end else begin
                pend_q <= (pend_q && !retire) || (accept && legal);
                if (retire) begin
                    words_q <= words_q + (ADDR_W+1)'(1);
                    if (!addr_max)
                        addr_q <= addr_q + ADDR_W'(1);
                    if (ovf_hit)
                        err_ovf_q <= 1'b1;
                end
                if (accept) begin
                    if (bus.in_last)
                        last_seen_q <= 1'b1;
                    if (legal) begin
                        wdata_q     <= enc;
                        pend_last_q <= bus.in_last;
                    end else begin
                        err_ill_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] ck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ck_q <= 32'h0;
        else if (start_run)
            ck_q <= 32'h0;
        else if (retire)
            ck_q <= ck_q ^ wdata_q;
    end

    assign checksum = ck_q;
`else
    assign checksum = 32'h0;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.imem_we    = pend_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = (state_q == S_DONE);
    assign err_illegal    = err_ill_q;
    assign err_ovf        = err_ovf_q;
    assign words          = words_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed bench with a run-level model and per-cycle write checker
module tb_instr_encoder;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          done;
    logic          err_illegal;
    logic          err_ovf;
    logic [AW:0]   words;
    logic [31:0]   checksum;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .bus(bus.slave), .done(done), .err_illegal(err_illegal),
        .err_ovf(err_ovf), .words(words), .checksum(checksum)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd2, rd1, rs2, rs1;
        logic [15:0] imm;
        logic [7:0]  sa, da;
    } instr_t;

    instr_t      prog[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  act_addr[$];
    logic [31:0] act_data[$];
    int          exp_words, exp_acc;
    logic        exp_ill, exp_ovf;
    logic [31:0] exp_ck;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, acc_cnt = 0, done_cnt = 0, wr_cnt = 0, stall_seen = 0, stall_cnt = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                                  input logic [4:0] rs2, input logic [4:0] rs1, input logic [15:0] imm,
                                  input logic [7:0] sa, input logic [7:0] da);
        instr_t i;
        i.op = op; i.rd2 = rd2; i.rd1 = rd1; i.rs2 = rs2; i.rs1 = rs1;
        i.imm = imm; i.sa = sa; i.da = da;
        return i;
    endfunction

    // Field layout from the format table, expressed as shifted fields
    function automatic logic [31:0] model_word(input instr_t i);
        logic [31:0] w;
        w = {i.op, 26'h0};
        if (i.op == 6'h00)      w = w | ({27'h0, i.rd2} << 21) | {16'h0, i.imm};
        else if (i.op == 6'h01) w = w | ({27'h0, i.rd2} << 21) | {27'h0, i.rs2};
        else if (i.op == 6'h02) w = w | ({27'h0, i.rd2} << 21) | {24'h0, i.sa};
        else if (i.op == 6'h03) w = w | ({24'h0, i.da} << 18) | {27'h0, i.rs2};
        else w = w | ({27'h0, i.rd2} << 21) | ({27'h0, i.rd1} << 16)
                   | ({27'h0, i.rs2} << 5) | {27'h0, i.rs1};
        return w;
    endfunction

    task automatic model_run(input logic [7:0] base, input bit last_flag);
        int addr;
        bit lastf;
        addr = base; exp_words = 0; exp_acc = 0; exp_ill = 0; exp_ovf = 0; exp_ck = 0;
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < prog.size(); i++) begin
            exp_acc++;
            lastf = last_flag && (i == prog.size() - 1);
            if (prog[i].op > 6'h10) begin
                exp_ill = 1;
                if (lastf) break;
                continue;
            end
            exp_addr.push_back(addr[7:0]);
            exp_data.push_back(model_word(prog[i]));
            exp_words++;
            exp_ck ^= model_word(prog[i]);
            if (lastf) break;
            if (addr == 255) begin
                exp_ovf = 1;
                break;
            end
            addr++;
        end
    endtask

    // Memory side: optionally stall a pending write for stall_cnt cycles
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0 && bus.imem_we) begin
            bus.imem_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.imem_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("hold_we", bus.imem_we, 1);
                chk("hold_addr", bus.imem_addr, prev_addr);
                chk("hold_wdata", bus.imem_wdata, prev_data);
            end
            if (bus.imem_we && !bus.imem_ready) begin
                stall_seen++;
                chk("stall_in_ready", bus.in_ready, 0);
            end
            if (bus.imem_we && bus.imem_ready) begin
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
                act_addr.push_back(bus.imem_addr);
                act_data.push_back(bus.imem_wdata);
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    chk("wr_addr", bus.imem_addr, exp_addr.pop_front());
                    chk("wr_data", bus.imem_wdata, exp_data.pop_front());
                end
            end
            prev_stall = bus.imem_we && !bus.imem_ready;
            prev_addr  = bus.imem_addr;
            prev_data  = bus.imem_wdata;
        end
    end

    task automatic send(input instr_t i, input bit last);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        bus.opcode = i.op; bus.rdst2 = i.rd2; bus.rdst1 = i.rd1; bus.rsrc2 = i.rs2;
        bus.rsrc1 = i.rs1; bus.imm = i.imm; bus.src_addr = i.sa; bus.dst_addr = i.da;
        bus.in_last = last; bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin acc = 1; break; end
            if (done) break;
            @(posedge clk); #1;
        end
        if (!acc && !done) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no handshake, expected acceptance or done");
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base);
        acc_cnt = 0; done_cnt = 0; wr_cnt = 0; stall_seen = 0;
        act_addr.delete(); act_data.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        base_addr = ~base;  // second start while running must be ignored
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_run(input string tag, input logic [7:0] base, input bit last_flag);
        model_run(base, last_flag);
        do_start(base);
        for (int i = 0; i < prog.size(); i++)
            send(prog[i], last_flag && (i == prog.size() - 1));
        idle_in();
        for (int t = 0; t < 50 && done_cnt == 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_words"}, words, exp_words);
        chk({tag, "_err_illegal"}, err_illegal, exp_ill);
        chk({tag, "_err_ovf"}, err_ovf, exp_ovf);
        chk({tag, "_accepted"}, acc_cnt, exp_acc);
        chk({tag, "_writes_left"}, exp_addr.size(), 0);
`ifdef ENC_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, exp_ck);
`else
        chk({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        int wr_before;
        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.opcode = '0; bus.rdst2 = '0;
        bus.rdst1 = '0; bus.rsrc2 = '0; bus.rsrc1 = '0; bus.imm = '0;
        bus.src_addr = '0; bus.dst_addr = '0; bus.imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words, 0);
        chk("rst_addr", bus.imem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        prog = '{mk(6'h00, 5'd3, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'h00, 8'h00)};
        do_run("t1", 8'h10, 1);
        chk("t1_lit_addr", act_addr.size() > 0 ? act_addr[0] : 8'hxx, 8'h10);
        chk("t1_lit_data", act_data.size() > 0 ? act_data[0] : 32'hx, 32'h0060BEEF);
        chk("t1_lit_words", words, 1);

        prog = '{mk(6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 8'h00, 8'h00),
                 mk(6'h03, 5'd0, 5'd0, 5'd5, 5'd0, 16'h0, 8'h00, 8'hAA),
                 mk(6'h01, 5'd7, 5'd0, 5'd9, 5'd0, 16'h0, 8'h00, 8'h00),
                 mk(6'h02, 5'd2, 5'd0, 5'd0, 5'd0, 16'h0, 8'h5C, 8'h00)};
        do_run("t2", 8'h20, 1);
        chk("t2_lit_data0", act_data.size() > 1 ? act_data[0] : 32'hx, 32'h10220064);
        chk("t2_lit_data1", act_data.size() > 1 ? act_data[1] : 32'hx, 32'h0EA80005);
        chk("t2_throughput", last_wr_cyc - first_wr_cyc, 3);

        prog = '{mk(6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'h1111, 8'h00, 8'h00),
                 mk(6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 16'h2222, 8'h00, 8'h00),
                 mk(6'h00, 5'd3, 5'd0, 5'd0, 5'd0, 16'h3333, 8'h00, 8'h00)};
        stall_cnt = 3;
        do_run("t3", 8'h30, 1);
        chk("t3_stall_cycles", stall_seen, 3);
        chk("t3_lit_words", words, 3);

        prog = '{mk(6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0042, 8'h00, 8'h00),
                 mk(6'h20, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 8'hFF, 8'hFF),
                 mk(6'h05, 5'd6, 5'd7, 5'd8, 5'd9, 16'h0, 8'h00, 8'h00)};
        do_run("t4", 8'h40, 1);
        chk("t4_lit_err_illegal", err_illegal, 1);
        chk("t4_lit_addr1", act_addr.size() > 1 ? act_addr[1] : 8'hxx, 8'h41);

        prog = '{mk(6'h00, 5'd4, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 8'h00),
                 mk(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 8'h00, 8'h00)};
        do_run("t5", 8'h60, 1);
        chk("t5_lit_words", words, 1);

        prog = '{mk(6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'hA001, 8'h00, 8'h00),
                 mk(6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 16'hA002, 8'h00, 8'h00),
                 mk(6'h00, 5'd3, 5'd0, 5'd0, 5'd0, 16'hA003, 8'h00, 8'h00)};
        do_run("t6", 8'hFE, 0);
        chk("t6_lit_err_ovf", err_ovf, 1);
        chk("t6_lit_words", words, 2);
        chk("t6_lit_accepted", acc_cnt, 2);

        // Reset while a write is stalled
        prog = '{mk(6'h00, 5'd5, 5'd0, 5'd0, 5'd0, 16'h5555, 8'h00, 8'h00)};
        model_run(8'h50, 0);
        stall_cnt = 1000;
        do_start(8'h50);
        send(prog[0], 0);
        idle_in();
        repeat (2) @(negedge clk);
        chk("t7_pending_before_rst", bus.imem_we, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_addr.delete(); exp_data.delete();
        stall_cnt = 0;
        #1;
        chk("t7_rst_imem_we", bus.imem_we, 0);
        chk("t7_rst_in_ready", bus.in_ready, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_addr", bus.imem_addr, 0);
        chk("t7_rst_wdata", bus.imem_wdata, 0);
        chk("t7_rst_words", words, 0);
        chk("t7_rst_errs", {err_illegal, err_ovf}, 0);
        chk("t7_rst_checksum", checksum, 0);
        wr_before = wr_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t7_no_write_after_rst", wr_cnt, wr_before);
        chk("t7_idle_in_ready", bus.in_ready, 0);

        prog = '{mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 8'h00, 8'h00),
                 mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0003, 8'h00, 8'h00)};
        do_run("t8", 8'h00, 1);
`ifdef ENC_CHECKSUM_EN
        chk("t8_lit_checksum", checksum, 32'h2);
`else
        chk("t8_lit_checksum", checksum, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width.
REQ-002 SHALL have these ports: clk, input, 1, the only clock, rising edge.
REQ-003 SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have these ports: start, input, 1, begin a load run; base_addr, input, ADDR_W, first write address.
REQ-005 SHALL have these ports: in_valid/in_ready, input/output, 1 each, instruction handshake; in_last, input, 1, marks final instruction.
REQ-006 SHALL have these ports: opcode, input, 6; rdst2/rdst1/rsrc2/rsrc1, input, 5 each; imm, input, 16; src_addr/dst_addr, input, 8 each.
REQ-007 SHALL have these ports: imem_we, output, 1; imem_ready, input, 1; imem_addr, output, ADDR_W; imem_wdata, output, 32.
REQ-008 SHALL have these ports: done, output, 1, one-cycle pulse; err_illegal/err_ovf, output, 1 each, sticky; words, output, ADDR_W+1, words written; checksum, output, 32.

Function
REQ-009 SHALL encode opcode into imem_wdata[31:26] for every format.
REQ-010 SHALL pack opcode 0x00 as {opcode, rdst2, 5'b0, imm}.
REQ-011 SHALL pack opcode 0x01 as {opcode, rdst2, 16'b0, rsrc2}.
REQ-012 SHALL pack opcode 0x02 as {opcode, rdst2, 13'b0, src_addr}.
REQ-013 SHALL pack opcode 0x03 as {opcode, dst_addr, 13'b0, rsrc2}.
REQ-014 SHALL pack opcodes 0x04-0x10 as {opcode, rdst2, rdst1, 6'b0, rsrc2, rsrc1}.
REQ-015 SHALL treat opcodes 0x11-0x3F as illegal: no write, err_illegal set; in_last is still honoured.
REQ-016 SHALL implement FSM IDLE, RUN, DONE: IDLE->RUN on start (latch base_addr, clear words, sticky errors and checksum); RUN->DONE when the in_last word (or dropped illegal) has been retired or on overflow; DONE->IDLE after one cycle with done=1.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL drive in_ready = RUN and (no pending write or imem_ready) and no in_last accepted yet.
REQ-019 SHALL register an accepted legal instruction into a one-entry output stage, giving imem_we=1 the following cycle (latency 1).
REQ-020 SHALL hold imem_we/addr/wdata stable while imem_we=1 and imem_ready=0.
REQ-021 SHALL allow acceptance of a new input in the same cycle the pending write retires (full throughput, one word per cycle).
REQ-022 SHALL increment imem_addr and words on each retired write (imem_we and imem_ready).
REQ-023 SHALL set err_ovf, deassert in_ready and enter DONE when a write retires at address all-ones and in_last has not been retired; the address SHALL NOT wrap.
REQ-024 SHALL make in_last on an illegal opcode enter DONE directly once no write is pending.

Reset
REQ-025 SHALL on rst_n=0, at any time including mid-run, immediately force IDLE, imem_we=0, in_ready=0, done=0, errors=0, words=0, imem_addr=0, imem_wdata=0, checksum=0.
REQ-026 SHALL drop any pending write on reset; no write SHALL follow deassertion without a new start.

Configuration
REQ-027 SHALL, when ENC_CHECKSUM_EN is defined, XOR each retired imem_wdata into checksum (cleared at start).
REQ-028 SHALL, when ENC_CHECKSUM_EN is not defined, tie checksum to 0 and omit its register.

Verification
REQ-029 SHALL cover: start with base 0x10; send opcode 0x00, rdst2=3, imm=0xBEEF, in_last -> write at 0x10 of 0x0060BEEF, done pulse, words=1.
REQ-030 SHALL cover: opcode 0x04, rdst2=1, rdst1=2, rsrc2=3, rsrc1=4 -> wdata 0x10220064; opcode 0x03, dst_addr=0xAA, rsrc2=5 -> 0x0EA80005.
REQ-031 SHALL cover: imem_ready low 3 cycles with in_valid high -> wdata/addr held, in_ready=0, no input lost, words counted once.
REQ-032 SHALL cover: opcode 0x20 mid-stream -> err_illegal=1, no write, next legal word at the unskipped address.
REQ-033 SHALL cover: base 0xFE, three words without in_last -> two writes, err_ovf=1, done pulse; third not accepted.
REQ-034 SHALL cover: rst_n low during stalled write -> imem_we=0 at once, IDLE; with ENC_CHECKSUM_EN, words 0x1 and 0x3 -> checksum 0x2.
